// File: rtl/ser_frame_tx.sv
// Serial frame transmitter: header 1011, PAYLOAD_W payload bits MSB first, then GAP_W idle zeros.
// One bit advance per Clk_EN strobe; a one-entry holding register decouples the load handshake from the line.
module ser_frame_tx #(
    parameter int PAYLOAD_W = 11,
    parameter int GAP_W     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Clk_EN,
    input  logic                 start,
    input  logic [PAYLOAD_W-1:0] data_in,
    output logic                 ready,
    output logic                 SerOut,
    output logic                 SerOutValid,
    output logic                 busy,
    output logic                 done
);

    localparam int MAX_PG = (PAYLOAD_W > GAP_W) ? PAYLOAD_W : GAP_W;
    localparam int MAX_C  = (MAX_PG > 4) ? MAX_PG : 4;
    localparam int CW     = $clog2(MAX_C) + 1;

    localparam logic [CW-1:0] HDR_LAST = CW'(3);
    localparam logic [CW-1:0] PAY_LAST = CW'(PAYLOAD_W - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_GAP} state_t;

    state_t                 state, state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic [PAYLOAD_W-1:0]   shreg, shreg_n;
    logic [PAYLOAD_W-1:0]   hold;
    logic                   hold_full;
    logic                   ser_q, ser_n;
    logic                   vld_q, vld_n;
    logic                   done_q, done_n;
    logic                   load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            shreg     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            ser_q     <= 1'b0;
            vld_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            shreg  <= shreg_n;
            ser_q  <= ser_n;
            vld_q  <= vld_n;
            done_q <= done_n;
            // A consume edge wins: ready was already low, so a coincident start is dropped.
            if (load) begin
                hold_full <= 1'b0;
            end else if (start && !hold_full) begin
                hold      <= data_in;
                hold_full <= 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        ser_n   = ser_q;
        vld_n   = vld_q;
        done_n  = 1'b0;
        load    = 1'b0;
        if (Clk_EN) begin
            case (state)
                S_IDLE: begin
                    ser_n = 1'b0;
                    vld_n = 1'b0;
                    load  = hold_full;
                end
                S_HDR: begin
                    if (cnt == HDR_LAST) begin
                        ser_n   = shreg[PAYLOAD_W-1];
                        vld_n   = 1'b1;
                        cnt_n   = '0;
                        state_n = S_PAY;
                    end else begin
                        // Remaining header bits after the leading 1 are 0,1,1.
                        ser_n = (cnt != '0);
                        cnt_n = cnt + CW'(1);
                    end
                end
                S_PAY: begin
                    if (cnt == PAY_LAST) begin
                        ser_n   = 1'b0;
                        vld_n   = 1'b0;
                        cnt_n   = '0;
                        state_n = S_GAP;
                    end else begin
                        shreg_n = shreg << 1;
                        ser_n   = shreg[PAYLOAD_W-2];
                        cnt_n   = cnt + CW'(1);
                    end
                end
                S_GAP: begin
                    ser_n = 1'b0;
                    if (cnt == GAP_LAST) begin
                        done_n  = 1'b1;
                        cnt_n   = '0;
                        state_n = S_IDLE;
                        load    = hold_full;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: state_n = S_IDLE;
            endcase
            if (load) begin
                shreg_n = hold;
                ser_n   = 1'b1;
                vld_n   = 1'b0;
                cnt_n   = '0;
                state_n = S_HDR;
            end
        end
    end

    assign ready       = !hold_full;
    assign SerOut      = ser_q;
    assign SerOutValid = vld_q;
    assign busy        = (state != S_IDLE);
    assign done        = done_q;

endmodule

// File: tb/tb_ser_frame_tx.sv
// Directed bench for ser_frame_tx: reset, idle, single frame, sparse strobes,
// back-to-back buffering, mid-frame reset and continuous start.
module tb_ser_frame_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        Clk_EN = 1'b0;
    logic        start = 1'b0;
    logic [10:0] data_in = '0;
    logic        ready, SerOut, SerOutValid, busy, done;

    int tests = 0;
    int fails = 0;

    ser_frame_tx #(.PAYLOAD_W(11), .GAP_W(1)) dut (
        .clk(clk), .rst(rst), .Clk_EN(Clk_EN), .start(start), .data_in(data_in),
        .ready(ready), .SerOut(SerOut), .SerOutValid(SerOutValid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // One clk edge with the given strobe; outputs are sampled 1 time unit later.
    task automatic tick(input logic en);
        Clk_EN = en;
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [10:0] d);
        start   = 1'b1;
        data_in = d;
        tick(1'b0);
        start   = 1'b0;
    endtask

    function automatic logic [10:0] dval(input int k);
        return 11'((k * 173 + 29) & 32'h7FF);
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        #12;
        tests++;
        if (SerOut !== 1'b0 || SerOutValid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
            fails++;
            $display("FAIL reset: SerOut=%b vld=%b busy=%b done=%b ready=%b, need 0 0 0 0 1",
                     SerOut, SerOutValid, busy, done, ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 24; i++) begin
            tick((i % 4) == 0);
            tests++;
            if (SerOut !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin
                fails++;
                $display("FAIL idle clk %0d: SerOut=%b ready=%b busy=%b, need 0 1 0", i, SerOut, ready, busy);
            end
        end
    endtask

    task automatic test_frame();
        logic [15:0] exp;
        exp = 16'hBA6C;  // 1011 10100110110 0
        accept(11'b101_0011_0110);
        tests++;
        if (ready !== 1'b0 || SerOut !== 1'b0) begin
            fails++;
            $display("FAIL frame accept: ready=%b SerOut=%b, need 0 0", ready, SerOut);
        end
        for (int i = 0; i < 16; i++) begin
            tick(1'b1);
            tests++;
            if (SerOut !== exp[15-i] || SerOutValid !== (i >= 4 && i <= 14) || busy !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("FAIL frame bit %0d: SerOut=%b vld=%b busy=%b done=%b, need %b %b 1 0",
                         i, SerOut, SerOutValid, busy, done, exp[15-i], (i >= 4 && i <= 14));
            end
            if (i == 0) begin
                tests++;
                if (ready !== 1'b1) begin
                    fails++;
                    $display("FAIL frame ready after consume: got %b need 1", ready);
                end
            end
        end
        tick(1'b1);
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || SerOut !== 1'b0) begin
            fails++;
            $display("FAIL frame end: done=%b busy=%b SerOut=%b, need 1 0 0", done, busy, SerOut);
        end
        tick(1'b1);
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL frame done pulse width: done=%b need 0", done);
        end
    endtask

    task automatic test_sparse();
        logic [15:0] exp;
        int          g;
        exp = 16'hBA6C;
        accept(11'b101_0011_0110);
        for (int i = 0; i < 16; i++) begin
            tick(1'b1);
            tests++;
            if (SerOut !== exp[15-i] || SerOutValid !== (i >= 4 && i <= 14)) begin
                fails++;
                $display("FAIL sparse bit %0d: SerOut=%b vld=%b, need %b %b",
                         i, SerOut, SerOutValid, exp[15-i], (i >= 4 && i <= 14));
            end
            g = 2 + $urandom_range(0, 2);
            for (int j = 0; j < g; j++) begin
                tick(1'b0);
                tests++;
                if (SerOut !== exp[15-i] || SerOutValid !== (i >= 4 && i <= 14) || busy !== 1'b1) begin
                    fails++;
                    $display("FAIL sparse hold bit %0d gap %0d: SerOut=%b vld=%b busy=%b, need %b %b 1",
                             i, j, SerOut, SerOutValid, busy, exp[15-i], (i >= 4 && i <= 14));
                end
            end
        end
        tick(1'b1);
        tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL sparse end: done=%b busy=%b, need 1 0", done, busy);
        end
        tick(1'b0);
        tests++;
        if (done !== 1'b0 || SerOut !== 1'b0) begin
            fails++;
            $display("FAIL sparse after end: done=%b SerOut=%b, need 0 0", done, SerOut);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        exp = {4'b1011, 11'h7FF, 1'b0, 4'b1011, 11'h001, 1'b0};
        accept(11'h7FF);
        for (int i = 0; i < 32; i++) begin
            if (i == 7) begin
                start = 1'b1;
                data_in = 11'h001;
            end else if (i >= 8 && i <= 16) begin
                start = 1'b1;
                data_in = 11'h555;
            end else begin
                start = 1'b0;
            end
            tick(1'b1);
            tests++;
            if (SerOut !== exp[31-i] || busy !== 1'b1) begin
                fails++;
                $display("FAIL b2b bit %0d: SerOut=%b busy=%b, need %b 1", i, SerOut, busy, exp[31-i]);
            end
            if (i == 7) begin
                tests++;
                if (ready !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b ready after B: got %b need 0", ready);
                end
            end
            if (i == 16) begin
                tests++;
                if (ready !== 1'b1 || done !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b consume of B: ready=%b done=%b, need 1 1", ready, done);
                end
            end
        end
        start = 1'b0;
        tick(1'b1);
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b end: done=%b busy=%b ready=%b, need 1 0 1", done, busy, ready);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b1);
            tests++;
            if (SerOut !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL b2b third start queued: SerOut=%b busy=%b, need 0 0", SerOut, busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp;
        accept(11'h4C3);
        for (int i = 0; i < 9; i++) tick(1'b1);
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if (SerOut !== 1'b0 || busy !== 1'b0 || SerOutValid !== 1'b0 || ready !== 1'b1) begin
            fails++;
            $display("FAIL midreset async: SerOut=%b busy=%b vld=%b ready=%b, need 0 0 0 1",
                     SerOut, busy, SerOutValid, ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick(1'b1);
        tests++;
        if (SerOut !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midreset idle: SerOut=%b busy=%b, need 0 0", SerOut, busy);
        end
        exp = {4'b1011, 11'h2AA, 1'b0};
        accept(11'h2AA);
        for (int i = 0; i < 16; i++) begin
            tick(1'b1);
            tests++;
            if (SerOut !== exp[15-i] || SerOutValid !== (i >= 4 && i <= 14)) begin
                fails++;
                $display("FAIL midreset frame bit %0d: SerOut=%b vld=%b, need %b %b",
                         i, SerOut, SerOutValid, exp[15-i], (i >= 4 && i <= 14));
            end
        end
        tick(1'b1);
        tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midreset frame end: done=%b busy=%b, need 1 0", done, busy);
        end
    endtask

    // Accepts land on edges 0, 2 (ready back after consume at 1) and 18 (after consume at 17);
    // the start at consume edge 33 is ignored.
    task automatic test_stream();
        logic [47:0] exp;
        exp = {4'b1011, dval(0), 1'b0, 4'b1011, dval(2), 1'b0, 4'b1011, dval(18), 1'b0};
        for (int k = 0; k < 50; k++) begin
            start   = (k <= 33);
            data_in = dval(k);
            tick(1'b1);
            if (k >= 1 && k <= 48) begin
                tests++;
                if (SerOut !== exp[48-k]) begin
                    fails++;
                    $display("FAIL stream bit %0d: SerOut=%b need %b", k - 1, SerOut, exp[48-k]);
                end
            end
            if (k == 49) begin
                tests++;
                if (done !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) begin
                    fails++;
                    $display("FAIL stream end: done=%b busy=%b ready=%b, need 1 0 1", done, busy, ready);
                end
            end
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_frame();
        test_sparse();
        test_back_to_back();
        test_reset_mid();
        test_stream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
